hazard_controller: RTL and testbench

Pipeline hazard sequencer for the 5-stage MIPS core. It keeps a shadow pipeline of per-instruction control (EX, MEM and WB entries) fed from the decoder outputs in ID. From that state it drives load-use stalls, wrong-path flushes for taken branches and jr, and EX-stage operand forwarding selects. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_controller_if.sv | 44 ++++
 rtl/hazard_controller.sv | 159 +++++++++++++++
 tb/tb_hazard_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Bundle between the decode stage and the hazard controller: ID fields and branch result in, stall/flush/forward controls out.
// Latency: pure wiring; the controller decides output timing.
// Backpressure: none at this level; stalls are carried as ordinary outputs.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    // ID-stage decoder view of the instruction currently in ID
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       id_dst;
    logic             id_RegWrite;
    logic             id_MemRead;
    logic [1:0]       id_PCsrc;
    // ALU branch condition for the instruction in EX
    logic             ex_cond_true;
    // Pipeline control outputs
    logic             stall_pc;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Pipeline side: supplies decode info, consumes control
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_RegWrite, id_MemRead, id_PCsrc, ex_cond_true,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_RegWrite, id_MemRead, id_PCsrc, ex_cond_true,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Shadow EX/MEM/WB control pipeline driving load-use stalls, branch/jr flushes and EX forwarding selects.
// Latency: all controls are combinational from the shadow state and ID fields; shadow advances every edge.
// Backpressure: a load-use stall holds PC and IF/ID and inserts one bubble into EX; redirect beats load-use.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_controller_if.slave hz
);

    localparam logic [1:0] PC_JR     = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
        logic [1:0] pcsrc;
    } ex_entry_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
    } late_entry_t;

    ex_entry_t   ex_q;
    ex_entry_t   ex_d;
    late_entry_t mem_q;
    late_entry_t wb_q;
    late_entry_t ex_as_late;

    logic redirect;
    logic load_use;
    logic rs_hit;
    logic rt_hit;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Forward source for one EX operand. A load sitting in MEM has no data
    // yet, so only ALU producers forward from MEM; WB covers both kinds.
    // Register 0 is hardwired and never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [4:0]  src,
        input logic        uses,
        input late_entry_t m,
        input late_entry_t w
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (uses && src != 5'd0) begin
            if (m.valid && m.reg_write && !m.mem_read && m.dst == src)
                sel = FWD_MEM;
            else if (w.valid && w.reg_write && w.dst == src)
                sel = FWD_WB;
        end
        return sel;
    endfunction

    // Control-flow redirect from the EX instruction; PCsrc 11 is sequential
    always_comb begin
        redirect = 1'b0;
        if (ex_q.valid) begin
            case (ex_q.pcsrc)
                PC_JR:     redirect = 1'b1;
                PC_BRANCH: redirect = hz.ex_cond_true;
                default:   redirect = 1'b0;
            endcase
        end
    end

    // Load-use detection; a wrong-path ID instruction (redirect) never stalls
    always_comb begin
        rs_hit   = hz.id_uses_rs && (hz.id_rs == ex_q.dst);
        rt_hit   = hz.id_uses_rt && (hz.id_rt == ex_q.dst);
        load_use = hz.id_valid && !redirect && ex_q.valid && ex_q.mem_read
                   && (ex_q.dst != 5'd0) && (rs_hit || rt_hit);
    end

    // Next EX entry: a bubble on flush, stall or empty ID; otherwise the ID fields
    always_comb begin
        ex_d = '0;
        if (hz.id_valid && !redirect && !load_use) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = hz.id_rs;
            ex_d.rt        = hz.id_rt;
            ex_d.uses_rs   = hz.id_uses_rs;
            ex_d.uses_rt   = hz.id_uses_rt;
            ex_d.dst       = hz.id_dst;
            ex_d.reg_write = hz.id_RegWrite;
            ex_d.mem_read  = hz.id_MemRead;
            ex_d.pcsrc     = hz.id_PCsrc;
        end
    end

    // Narrow the EX entry to what MEM and WB still need
    always_comb begin
        ex_as_late           = '0;
        ex_as_late.valid     = ex_q.valid;
        ex_as_late.dst       = ex_q.dst;
        ex_as_late.reg_write = ex_q.reg_write;
        ex_as_late.mem_read  = ex_q.mem_read;
    end

    // Shadow pipeline advances every cycle; the MEM/WB stages never stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_as_late;
            wb_q  <= mem_q;
        end
    end

    // Saturating event counters for performance debug
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    // Output drive; forwarding is meaningless without a valid EX instruction
    always_comb begin
        hz.stall_pc    = load_use;
        hz.stall_if_id = load_use;
        hz.flush_if_id = redirect;
        hz.flush_id_ex = redirect || load_use;
        hz.fwd_a_sel   = FWD_REG;
        hz.fwd_b_sel   = FWD_REG;
        if (ex_q.valid) begin
            hz.fwd_a_sel = fwd_select(ex_q.rs, ex_q.uses_rs, mem_q, wb_q);
            hz.fwd_b_sel = fwd_select(ex_q.rt, ex_q.uses_rt, mem_q, wb_q);
        end
        hz.stall_count = stall_cnt_q;
        hz.flush_count = flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a wide-counter and a 2-bit-counter instance share all stimulus.
// Latency: expected per-cycle outputs are queued as stimulus is driven and compared #1 after the falling edge.
// Backpressure: the bench models the held IF/ID by re-driving the stalled ID instruction.
module tb_hazard_controller;

    logic clk;
    logic rst;

    hazard_controller_if #(.CNT_W(16)) hz1 ();
    hazard_controller_if #(.CNT_W(2))  hz2 ();

    hazard_controller #(.CNT_W(16)) u_dut_wide (
        .clk (clk),
        .rst (rst),
        .hz  (hz1.slave)
    );

    hazard_controller #(.CNT_W(2)) u_dut_narrow (
        .clk (clk),
        .rst (rst),
        .hz  (hz2.slave)
    );

    typedef struct {
        logic       stall;
        logic       fl_ifid;
        logic       fl_idex;
        logic [1:0] fa;
        logic [1:0] fb;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic st, input logic fi, input logic fe,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input int sc, input int fc);
        exp_t e;
        e.stall = st; e.fl_ifid = fi; e.fl_idex = fe;
        e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic mr, input logic [1:0] pc);
        hz1.id_valid = v;  hz2.id_valid = v;
        hz1.id_rs = rs;    hz2.id_rs = rs;
        hz1.id_rt = rt;    hz2.id_rt = rt;
        hz1.id_uses_rs = urs; hz2.id_uses_rs = urs;
        hz1.id_uses_rt = urt; hz2.id_uses_rt = urt;
        hz1.id_dst = dst;  hz2.id_dst = dst;
        hz1.id_RegWrite = rw; hz2.id_RegWrite = rw;
        hz1.id_MemRead = mr;  hz2.id_MemRead = mr;
        hz1.id_PCsrc = pc; hz2.id_PCsrc = pc;
    endtask

    task automatic set_cond(input logic c);
        hz1.ex_cond_true = c;
        hz2.ex_cond_true = c;
    endtask

    task automatic id_nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic id_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic id_lw(input logic [4:0] rt, input logic [4:0] base);
        drive(1'b1, base, rt, 1'b1, 1'b0, rt, 1'b1, 1'b1, 2'b00);
    endtask

    task automatic id_beq(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b10);
    endtask

    // Queue the expected outputs for the cycle just driven, then pop and compare
    task automatic step(input string nm, input exp_t e);
        exp_t x;
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        checks++;
        if (hz1.stall_pc !== x.stall) begin
            errors++; $display("FAIL %s stall_pc got %b want %b", nm, hz1.stall_pc, x.stall);
        end
        checks++;
        if (hz1.stall_if_id !== x.stall) begin
            errors++; $display("FAIL %s stall_if_id got %b want %b", nm, hz1.stall_if_id, x.stall);
        end
        checks++;
        if (hz1.flush_if_id !== x.fl_ifid) begin
            errors++; $display("FAIL %s flush_if_id got %b want %b", nm, hz1.flush_if_id, x.fl_ifid);
        end
        checks++;
        if (hz1.flush_id_ex !== x.fl_idex) begin
            errors++; $display("FAIL %s flush_id_ex got %b want %b", nm, hz1.flush_id_ex, x.fl_idex);
        end
        checks++;
        if (hz1.fwd_a_sel !== x.fa) begin
            errors++; $display("FAIL %s fwd_a_sel got %b want %b", nm, hz1.fwd_a_sel, x.fa);
        end
        checks++;
        if (hz1.fwd_b_sel !== x.fb) begin
            errors++; $display("FAIL %s fwd_b_sel got %b want %b", nm, hz1.fwd_b_sel, x.fb);
        end
        checks++;
        if (hz1.stall_count !== 16'(x.sc)) begin
            errors++; $display("FAIL %s stall_count got %0d want %0d", nm, hz1.stall_count, x.sc);
        end
        checks++;
        if (hz1.flush_count !== 16'(x.fc)) begin
            errors++; $display("FAIL %s flush_count got %0d want %0d", nm, hz1.flush_count, x.fc);
        end
        checks++;
        if (hz2.stall_count !== 2'(sat3(x.sc))) begin
            errors++; $display("FAIL %s narrow stall_count got %0d want %0d", nm, hz2.stall_count, sat3(x.sc));
        end
        checks++;
        if (hz2.flush_count !== 2'(sat3(x.fc))) begin
            errors++; $display("FAIL %s narrow flush_count got %0d want %0d", nm, hz2.flush_count, sat3(x.fc));
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        id_nop();
        set_cond(1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_nop();
        set_cond(1'b0);
        step("reset_idle", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd6, 5'd2, 5'd5);
        set_cond(1'b1);
        step("reset_held", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        rst = 1'b0;
        step("reset_release", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        set_cond(1'b0);
    endtask

    task automatic test_forward();
        apply_reset();
        id_alu(5'd3, 5'd1, 5'd2);
        step("fwd_mem_c0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd4, 5'd3, 5'd7);
        step("fwd_mem_c1", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("fwd_mem_sub", mk(0, 0, 0, 2'b01, 2'b00, 0, 0));

        apply_reset();
        id_alu(5'd3, 5'd1, 5'd2);
        step("fwd_wb_c0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd8, 5'd1, 5'd2);
        step("fwd_wb_c1", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd4, 5'd3, 5'd7);
        step("fwd_wb_c2", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("fwd_wb_sub", mk(0, 0, 0, 2'b10, 2'b00, 0, 0));

        apply_reset();
        id_alu(5'd3, 5'd1, 5'd2);
        step("fwd_prio_c0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd3, 5'd4, 5'd5);
        step("fwd_prio_c1", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd4, 5'd3, 5'd3);
        step("fwd_prio_c2", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("fwd_prio_sub", mk(0, 0, 0, 2'b01, 2'b01, 0, 0));
    endtask

    task automatic test_load_use();
        apply_reset();
        id_lw(5'd5, 5'd2);
        step("lu_lw", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd6, 5'd2, 5'd5);
        step("lu_stall", mk(1, 0, 1, 2'b00, 2'b00, 0, 0));
        step("lu_held", mk(0, 0, 0, 2'b00, 2'b00, 1, 0));
        id_nop();
        step("lu_consumer", mk(0, 0, 0, 2'b00, 2'b10, 1, 0));
    endtask

    task automatic test_branch();
        apply_reset();
        id_beq(5'd1, 5'd2);
        step("br_t_c0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd9, 5'd1, 5'd2);
        set_cond(1'b1);
        step("br_taken", mk(0, 1, 1, 2'b00, 2'b00, 0, 0));
        id_nop();
        set_cond(1'b0);
        step("br_after", mk(0, 0, 0, 2'b00, 2'b00, 0, 1));

        apply_reset();
        id_beq(5'd1, 5'd2);
        step("br_nt_c0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd9, 5'd1, 5'd2);
        step("br_not_taken", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("br_nt_after", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
    endtask

    task automatic test_reg0_and_priority();
        apply_reset();
        id_lw(5'd0, 5'd1);
        step("r0_lw", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd6, 5'd0, 5'd0);
        step("r0_no_stall", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd7, 5'd0, 5'd0);
        step("r0_ex_add", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("r0_wb", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));

        // jr whose EX entry also carries a load to r5: redirect must win
        apply_reset();
        drive(1'b1, 5'd31, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 2'b01);
        step("prio_jr", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd6, 5'd2, 5'd5);
        step("prio_flush_only", mk(0, 1, 1, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("prio_after", mk(0, 0, 0, 2'b00, 2'b00, 0, 1));
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            id_lw(5'd5, 5'd2);
            step("sat_lw", mk(0, 0, 0, 2'b00, (k > 0) ? 2'b10 : 2'b00, k, 0));
            id_alu(5'd6, 5'd2, 5'd5);
            step("sat_stall", mk(1, 0, 1, 2'b00, 2'b00, k, 0));
            step("sat_held", mk(0, 0, 0, 2'b00, 2'b00, k + 1, 0));
        end
        id_nop();
        step("sat_final", mk(0, 0, 0, 2'b00, 2'b10, 5, 0));
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        id_lw(5'd5, 5'd2);
        step("rms_lw0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_alu(5'd6, 5'd2, 5'd5);
        step("rms_stall0", mk(1, 0, 1, 2'b00, 2'b00, 0, 0));
        step("rms_held0", mk(0, 0, 0, 2'b00, 2'b00, 1, 0));
        id_lw(5'd5, 5'd2);
        step("rms_lw1", mk(0, 0, 0, 2'b00, 2'b10, 1, 0));
        id_alu(5'd6, 5'd2, 5'd5);
        #1;
        checks++;
        if (hz1.stall_pc !== 1'b1) begin
            errors++; $display("FAIL rms_pre stall_pc got %b want 1", hz1.stall_pc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({hz1.stall_pc, hz1.stall_if_id, hz1.flush_if_id, hz1.flush_id_ex,
             hz1.fwd_a_sel, hz1.fwd_b_sel} !== 8'h00) begin
            errors++;
            $display("FAIL rms_immediate outputs got %b%b%b%b %b %b want all 0",
                     hz1.stall_pc, hz1.stall_if_id, hz1.flush_if_id, hz1.flush_id_ex,
                     hz1.fwd_a_sel, hz1.fwd_b_sel);
        end
        checks++;
        if (hz1.stall_count !== 16'd0 || hz2.stall_count !== 2'd0) begin
            errors++;
            $display("FAIL rms_counter stall_count got %0d/%0d want 0/0", hz1.stall_count, hz2.stall_count);
        end
        @(negedge clk);
        step("rms_held_rst", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        rst = 1'b0;
        step("rms_release", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_nop();
        step("rms_after", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_reg0_and_priority();
        test_saturation();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
